// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
// Program-counter register and instruction-fetch sequencer for the
// single-cycle RISC-V core.
//
// After reset it fetches from RESET_PC. Each fetch uses a request/grant/response
// handshake with instruction memory. The fetched word is held for decode while
// instr_valid is high. On commit (pc_we) the PC is loaded from the PC-source mux
// and the next fetch starts. A misaligned target or a memory that stops
// responding puts the block into a sticky fault state, which only rst_n clears.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//   TIMEOUT      max consecutive wait cycles in REQ/WAIT before fault (0 = off)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   pc_next      next PC from the PC-source mux
//   pc_we        commit strobe, honoured only while an instruction is executing
//   imem_req     fetch request
//   imem_addr    fetch address (always equals pc)
//   imem_gnt     memory accepted the request
//   imem_rvalid  read data valid
//   imem_rdata   read data
//   instr        captured instruction word (NOP after reset)
//   instr_valid  instr is valid for the current pc
//   pc           current PC
//   pc4          pc + 4, modulo 2^32, fed back to the mux
//   fault        sticky fault flag
//   fault_cause  00 none, 01 misaligned, 10 timeout
// -----------------------------------------------------------------------------
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_next,
   input  logic        pc_we,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic        fault,
   output logic [1:0]  fault_cause
);

   typedef enum logic [2:0] {
      S_RESET,
      S_REQ,
      S_WAIT,
      S_EXEC,
      S_FAULT
   } state_t;

   localparam logic [31:0] NOP         = 32'h0000_0013;
   localparam logic [1:0]  CAUSE_NONE  = 2'b00;
   localparam logic [1:0]  CAUSE_ALIGN = 2'b01;
   localparam logic [1:0]  CAUSE_TMO   = 2'b10;

   // The counter never has to count past TIMEOUT. When the timeout is
   // disabled, a single bit is kept and simply wraps.
   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO_VAL = CW'(TIMEOUT);

   state_t          state, state_d;
   logic [31:0]     pc_d;
   logic [31:0]     instr_d;
   logic [CW-1:0]   cnt, cnt_d;
   logic [1:0]      cause_d;
   logic            timeout_hit;

   assign timeout_hit = (TIMEOUT != 0) && (cnt == TMO_VAL);

   // Next-state and datapath updates
   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // skipped one would otherwise infer a latch.
      state_d = state;
      pc_d    = pc;
      instr_d = instr;
      cnt_d   = cnt;
      cause_d = fault_cause;

      case (state)
         S_RESET: begin
            cnt_d = '0;
            if (RESET_PC[1:0] != 2'b00) begin
               state_d = S_FAULT;
               cause_d = CAUSE_ALIGN;
            end else begin
               state_d = S_REQ;
            end
         end

         S_REQ: begin
            // Progress (a grant) wins over a timeout that expires in the same cycle.
            if (imem_gnt) begin
               cnt_d = '0;
               if (imem_rvalid) begin
                  instr_d = imem_rdata;
                  state_d = S_EXEC;
               end else begin
                  state_d = S_WAIT;
               end
            end else if (timeout_hit) begin
               state_d = S_FAULT;
               cause_d = CAUSE_TMO;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end

         S_WAIT: begin
            if (imem_rvalid) begin
               instr_d = imem_rdata;
               state_d = S_EXEC;
            end else if (timeout_hit) begin
               state_d = S_FAULT;
               cause_d = CAUSE_TMO;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end

         S_EXEC: begin
            if (pc_we) begin
               // A misaligned target is still loaded so it is visible for debug.
               pc_d = pc_next;
               if (pc_next[1:0] != 2'b00) begin
                  state_d = S_FAULT;
                  cause_d = CAUSE_ALIGN;
               end else begin
                  state_d = S_REQ;
                  cnt_d   = '0;
               end
            end
         end

         S_FAULT: begin
            // Sticky until reset. All inputs are ignored.
         end

         default: begin
            state_d = S_FAULT;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_RESET;
         pc          <= RESET_PC;
         instr       <= NOP;
         cnt         <= '0;
         fault_cause <= CAUSE_NONE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so that every
         // register samples values from before the edge.
         state       <= state_d;
         pc          <= pc_d;
         instr       <= instr_d;
         cnt         <= cnt_d;
         fault_cause <= cause_d;
      end
   end

   assign imem_req    = (state == S_REQ);
   assign imem_addr   = pc;
   assign instr_valid = (state == S_EXEC);
   assign fault       = (state == S_FAULT);
   assign pc4         = pc + 32'd4;

endmodule

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch
// Self-checking bench for pc_fetch. The bench plays the role of the memory
// and uses a simple reference model. The model tracks the expected PC, treats
// a fetch with an N-cycle grant delay and an M-cycle data delay as N+M+1
// cycles, and expects the word the memory returned. A second instance with a
// misaligned RESET_PC checks the fault taken straight out of reset.
// -----------------------------------------------------------------------------
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_next;
   logic        pc_we;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        fault;
   logic [1:0]  fault_cause;

   logic        b_req;
   logic [31:0] b_addr;
   logic [31:0] b_instr;
   logic        b_valid;
   logic [31:0] b_pc;
   logic [31:0] b_pc4;
   logic        b_fault;
   logic [1:0]  b_cause;

   int passed = 0;
   int total  = 0;
   int fails  = 0;
   logic [31:0] exp_pc;

   always #5 clk = ~clk;

   pc_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .pc_we(pc_we),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
      .instr_valid(instr_valid), .pc(pc), .pc4(pc4), .fault(fault),
      .fault_cause(fault_cause)
   );

   pc_fetch #(.RESET_PC(32'h0000_0002), .TIMEOUT(8)) dut_bad (
      .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .pc_we(pc_we),
      .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(b_instr),
      .instr_valid(b_valid), .pc(b_pc), .pc4(b_pc4), .fault(b_fault),
      .fault_cause(b_cause)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called in the first REQ cycle (at the negedge). Grant arrives after n idle
   // request cycles, and data arrives m cycles after the grant.
   task automatic fetch(input int n, input int m, input logic [31:0] data);
      for (int c = 1; c <= n + m + 1; c++) begin
         if (c <= n + 1) begin
            check("req_high", {31'd0, imem_req}, 32'd1);
            check("addr_stable", imem_addr, exp_pc);
         end else begin
            check("req_low_wait", {31'd0, imem_req}, 32'd0);
         end
         check("valid_low_fetch", {31'd0, instr_valid}, 32'd0);
         check("no_fault_fetch", {31'd0, fault}, 32'd0);
         if (c == n + 1)     imem_gnt = 1'b1;
         else if (c > n + 1) imem_gnt = 1'($urandom_range(0, 1));
         else                imem_gnt = 1'b0;
         imem_rvalid = (c == n + 1 + m);
         imem_rdata  = imem_rvalid ? data : $urandom;
         pc_we       = 1'($urandom_range(0, 1));
         pc_next     = $urandom;
         step();
      end
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      pc_we       = 1'b0;
      check("valid_high", {31'd0, instr_valid}, 32'd1);
      check("instr", instr, data);
      check("pc_held", pc, exp_pc);
   endtask

   // Called in an EXEC cycle (at the negedge).
   task automatic commit(input logic [31:0] target);
      pc_we   = 1'b1;
      pc_next = target;
      step();
      pc_we   = 1'b0;
      exp_pc  = target;
      check("pc_commit", pc, exp_pc);
      check("pc4_commit", pc4, exp_pc + 32'd4);
      check("addr_commit", imem_addr, exp_pc);
      check("valid_drop", {31'd0, instr_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0] data;
      int          n, m, dwell;

      rst_n       = 1'b0;
      pc_we       = 1'b0;
      pc_next     = '0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      exp_pc      = 32'h0;
      repeat (2) @(negedge clk);

      // Values while reset is held low
      check("rst_pc", pc, 32'h0);
      check("rst_instr", instr, 32'h0000_0013);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      check("rst_cause", {30'd0, fault_cause}, 32'd0);
      check("rst_pc4", pc4, 32'd4);

      // Release reset. Cycle 0 is still the reset state.
      rst_n = 1'b1;
      check("c0_req", {31'd0, imem_req}, 32'd0);
      check("bad_c0_fault", {31'd0, b_fault}, 32'd0);
      step();
      check("bad_fault", {31'd0, b_fault}, 32'd1);
      check("bad_cause", {30'd0, b_cause}, 32'd1);
      check("bad_req", {31'd0, b_req}, 32'd0);
      check("bad_pc", b_pc, 32'h2);

      // Zero-wait fetch of 0x93 at address 0
      fetch(0, 0, 32'h0000_0093);
      check("pc4_first", pc4, 32'd4);

      // Sequential commits with grant delay 2 and data delay 1
      for (int i = 0; i < 3; i++) begin
         commit(exp_pc + 32'd4);
         fetch(2, 1, 32'h1000_0000 + 32'(i));
      end
      check("seq_addr", imem_addr, 32'hC);

      // Random aligned targets, delays and dwell time in EXEC
      for (int i = 0; i < 20; i++) begin
         dwell = $urandom_range(0, 2);
         for (int k = 0; k < dwell; k++) begin
            data = instr;
            step();
            check("exec_hold_valid", {31'd0, instr_valid}, 32'd1);
            check("exec_hold_instr", instr, data);
         end
         commit($urandom & 32'hFFFF_FFFC);
         n = $urandom_range(0, 3);
         m = $urandom_range(0, 3);
         fetch(n, m, $urandom);
      end

      // PC wrap-around
      commit(32'hFFFF_FFFC);
      check("wrap_pc4", pc4, 32'h0);
      fetch(1, 0, 32'hAAAA_5555);
      commit(32'h0);
      fetch(0, 2, 32'h5555_AAAA);

      // Grant on the 8th and 9th wait cycles beats a timeout of 8
      commit(32'h0000_0200);
      fetch(7, 2, 32'h0000_0777);
      commit(32'h0000_0204);
      fetch(8, 0, 32'h0000_0888);

      // Memory never grants: the fault appears 9 cycles after REQ entry
      commit(32'h0000_0300);
      for (int c = 1; c <= 9; c++) begin
         check("tmo_pending_fault", {31'd0, fault}, 32'd0);
         check("tmo_pending_req", {31'd0, imem_req}, 32'd1);
         step();
      end
      check("tmo_fault", {31'd0, fault}, 32'd1);
      check("tmo_cause", {30'd0, fault_cause}, 32'd2);
      check("tmo_req", {31'd0, imem_req}, 32'd0);

      // Reset out of the timeout fault, then reset again mid-WAIT
      rst_n = 1'b0;
      #1;
      check("rst2_fault", {31'd0, fault}, 32'd0);
      check("rst2_cause", {30'd0, fault_cause}, 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      exp_pc = 32'h0;
      step();
      fetch(0, 0, 32'h0000_0013);
      commit(32'h0000_0040);
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      check("wait_req", {31'd0, imem_req}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midwait_req", {31'd0, imem_req}, 32'd0);
      check("midwait_pc", pc, 32'h0);
      check("midwait_instr", instr, 32'h0000_0013);
      check("midwait_valid", {31'd0, instr_valid}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      rst_n  = 1'b1;
      exp_pc = 32'h0;
      check("stray_c0_valid", {31'd0, instr_valid}, 32'd0);
      check("stray_c0_instr", instr, 32'h0000_0013);
      step();
      fetch(1, 1, 32'h0000_0123);

      // Misaligned commit: sticky fault, bad PC kept
      pc_we   = 1'b1;
      pc_next = 32'h0000_0102;
      step();
      pc_we = 1'b0;
      check("mis_fault", {31'd0, fault}, 32'd1);
      check("mis_cause", {30'd0, fault_cause}, 32'd1);
      check("mis_pc", pc, 32'h0000_0102);
      for (int c = 0; c < 6; c++) begin
         imem_gnt    = 1'($urandom_range(0, 1));
         imem_rvalid = 1'($urandom_range(0, 1));
         imem_rdata  = $urandom;
         pc_we       = 1'($urandom_range(0, 1));
         pc_next     = $urandom & 32'hFFFF_FFFC;
         step();
         check("sticky_fault", {31'd0, fault}, 32'd1);
         check("sticky_req", {31'd0, imem_req}, 32'd0);
         check("sticky_valid", {31'd0, instr_valid}, 32'd0);
         check("sticky_pc", pc, 32'h0000_0102);
         check("sticky_instr", instr, 32'h0000_0123);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
